// File: rtl/eros_pkg.sv
// Shared OBI bus types and safe-CSR address map for the EROS core subsystem.
package eros_pkg;

   localparam logic [31:0] SAFE_CPU_REGISTER_START_ADDRESS = 32'h2000_0000;
   localparam logic [31:0] SAFE_CPU_REGISTER_END_ADDRESS   = 32'h2000_1000;

   localparam int unsigned DEMUX_INT_XBAR_IDX          = 0;
   localparam int unsigned DEMUX_SAFE_CPU_REGISTER_IDX = 1;

   typedef struct packed {
      logic        req;
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_resp_t;

endpackage

// File: rtl/safe_reg_demux.sv
// Routes core OBI data requests either to the internal crossbar or to the safe
// CPU register block, keeping in-order responses by tracking one target at a time.
module safe_reg_demux #(
   parameter logic [31:0] SafeStart      = eros_pkg::SAFE_CPU_REGISTER_START_ADDRESS,
   parameter logic [31:0] SafeEnd        = eros_pkg::SAFE_CPU_REGISTER_END_ADDRESS,
   parameter int unsigned MaxOutstanding = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  eros_pkg::obi_req_t         master_req_i,
   output eros_pkg::obi_resp_t        master_resp_o,
   output eros_pkg::obi_req_t  [1:0]  slave_req_o,
   input  eros_pkg::obi_resp_t [1:0]  slave_resp_i,
   output logic                       err_o
);

   localparam int unsigned XbarIdx = eros_pkg::DEMUX_INT_XBAR_IDX;
   localparam int unsigned SafeIdx = eros_pkg::DEMUX_SAFE_CPU_REGISTER_IDX;
   localparam logic [3:0]  MaxCnt  = 4'(MaxOutstanding);

   logic [3:0] cnt;
   logic [3:0] cnt_next;
   logic       last_sel;
   logic       sel;
   logic       allowed;
   logic       grant;
   logic       fwd_rvalid;
   logic       proto_err;

   // NOTE: every signal gets a default at the top of the block so no path
   // through the combinational logic can leave it unassigned and infer a latch.
   always_comb begin
      sel      = (master_req_i.addr >= SafeStart) && (master_req_i.addr < SafeEnd);
      // A new target is only accepted once every response from the old one is back.
      allowed  = !rst_i && ((cnt == 4'd0) || (sel == last_sel)) && (cnt < MaxCnt);

      slave_req_o[XbarIdx]     = master_req_i;
      slave_req_o[SafeIdx]     = master_req_i;
      slave_req_o[XbarIdx].req = 1'b0;
      slave_req_o[SafeIdx].req = 1'b0;
      slave_req_o[sel].req     = master_req_i.req && allowed;

      grant      = master_req_i.req && allowed && slave_resp_i[sel].gnt;
      fwd_rvalid = !rst_i && (cnt != 4'd0) && slave_resp_i[last_sel].rvalid;

      master_resp_o.gnt    = grant;
      master_resp_o.rvalid = fwd_rvalid;
      master_resp_o.rdata  = slave_resp_i[last_sel].rdata;

      proto_err = slave_resp_i[!last_sel].rvalid
               || (slave_resp_i[last_sel].rvalid && (cnt == 4'd0))
               || (slave_resp_i[XbarIdx].gnt && !slave_req_o[XbarIdx].req)
               || (slave_resp_i[SafeIdx].gnt && !slave_req_o[SafeIdx].req);

      // allowed and the cnt != 0 guard on rvalid keep this from ever wrapping.
      cnt_next = cnt;
      case ({grant, fwd_rvalid})
         2'b10:   cnt_next = cnt + 4'd1;
         2'b01:   cnt_next = cnt - 4'd1;
         default: cnt_next = cnt;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values, independent of the order statements appear in.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt      <= 4'd0;
         last_sel <= 1'b0;
         err_o    <= 1'b0;
      end else begin
         cnt <= cnt_next;
         if (grant) begin
            last_sel <= sel;
         end
         if (proto_err) begin
            err_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_safe_reg_demux.sv
// Directed bench for safe_reg_demux: address decode, outstanding limit,
// target switching, protocol errors and reset mid-transaction.
module tb_safe_reg_demux;

   logic                      clk = 1'b0;
   logic                      rst_i;
   eros_pkg::obi_req_t        master_req;
   eros_pkg::obi_resp_t       master_resp;
   eros_pkg::obi_req_t  [1:0] slave_req;
   eros_pkg::obi_resp_t [1:0] slave_resp;
   logic                      err;

   logic [1:0]  gnt_en;
   logic [1:0]  rv;
   logic [31:0] rd0;
   logic [31:0] rd1;

   int total = 0;
   int bad   = 0;

   safe_reg_demux #(
      .SafeStart      (32'h3000_0000),
      .SafeEnd        (32'h3000_0100),
      .MaxOutstanding (2)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .master_req_i  (master_req),
      .master_resp_o (master_resp),
      .slave_req_o   (slave_req),
      .slave_resp_i  (slave_resp),
      .err_o         (err)
   );

   always #5 clk = ~clk;

   // Slave models grant only what is requested of them.
   assign slave_resp[0] = '{gnt: gnt_en[0] & slave_req[0].req, rvalid: rv[0], rdata: rd0};
   assign slave_resp[1] = '{gnt: gnt_en[1] & slave_req[1].req, rvalid: rv[1], rdata: rd1};

   // {master gnt, master rvalid, slave0 req, slave1 req, err}
   function automatic logic [4:0] obs();
      return {master_resp.gnt, master_resp.rvalid, slave_req[0].req, slave_req[1].req, err};
   endfunction

   // Drive one cycle's inputs just after the falling edge and settle before sampling.
   task automatic step(input logic rst, input logic req, input logic [31:0] addr,
                       input logic [1:0] rvalid, input logic [31:0] rdata);
      @(negedge clk);
      rst_i           = rst;
      master_req.req  = req;
      master_req.addr = addr;
      rv              = rvalid;
      rd0             = rvalid[0] ? rdata : 32'hDEAD_BEEF;
      rd1             = rvalid[1] ? rdata : 32'hBAD0_BAD0;
      #1;
   endtask

   task automatic test_reset();
      step(1'b1, 1'b1, 32'h3000_0004, 2'b00, 32'h0);
      @(posedge clk);
      step(1'b1, 1'b1, 32'h3000_0004, 2'b00, 32'h0);
      total++;
      if (obs() !== 5'b00000) begin
         bad++; $display("FAIL reset_outputs: got %b want %b", obs(), 5'b00000);
      end
      step(1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
      total++;
      if (obs() !== 5'b00000) begin
         bad++; $display("FAIL reset_idle: got %b want %b", obs(), 5'b00000);
      end
   endtask

   task automatic test_safe_read();
      master_req.we    = 1'b1;
      master_req.be    = 4'hA;
      master_req.wdata = 32'h1234_5678;
      step(1'b0, 1'b1, 32'h3000_0004, 2'b00, 32'h0);
      total++;
      if (obs() !== 5'b10010) begin
         bad++; $display("FAIL safe_read_grant: got %b want %b", obs(), 5'b10010);
      end
      total++;
      if ({slave_req[0].addr, slave_req[0].we, slave_req[0].be, slave_req[0].wdata} !==
          {32'h3000_0004, 1'b1, 4'hA, 32'h1234_5678}) begin
         bad++; $display("FAIL passthru_port0: got %h want %h", slave_req[0].addr, 32'h3000_0004);
      end
      total++;
      if ({slave_req[1].addr, slave_req[1].we, slave_req[1].be, slave_req[1].wdata} !==
          {32'h3000_0004, 1'b1, 4'hA, 32'h1234_5678}) begin
         bad++; $display("FAIL passthru_port1: got %h want %h", slave_req[1].addr, 32'h3000_0004);
      end
      master_req.we = 1'b0;
      step(1'b0, 1'b0, 32'h0, 2'b10, 32'hCAFE_0001);
      total++;
      if (obs() !== 5'b01000) begin
         bad++; $display("FAIL safe_read_rvalid: got %b want %b", obs(), 5'b01000);
      end
      total++;
      if (master_resp.rdata !== 32'hCAFE_0001) begin
         bad++; $display("FAIL safe_read_rdata: got %h want %h", master_resp.rdata, 32'hCAFE_0001);
      end
      step(1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
      total++;
      if (obs() !== 5'b00000) begin
         bad++; $display("FAIL safe_read_done: got %b want %b", obs(), 5'b00000);
      end
   endtask

   task automatic test_boundary();
      logic [31:0] addrs [4] = '{32'h3000_0100, 32'h2FFF_FFFC, 32'h3000_00FC, 32'h3000_0000};
      logic [4:0]  want  [4] = '{5'b10100, 5'b10100, 5'b10010, 5'b10010};
      logic [1:0]  port  [4] = '{2'b01, 2'b01, 2'b10, 2'b10};
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, addrs[i], 2'b00, 32'h0);
         total++;
         if (obs() !== want[i]) begin
            bad++; $display("FAIL boundary_%0d addr %h: got %b want %b", i, addrs[i], obs(), want[i]);
         end
         step(1'b0, 1'b0, 32'h0, port[i], 32'h5A00_0000 + i);
         total++;
         if ({obs(), master_resp.rdata} !== {5'b01000, 32'h5A00_0000 + i}) begin
            bad++; $display("FAIL boundary_resp_%0d: got %b/%h want %b/%h", i, obs(),
                            master_resp.rdata, 5'b01000, 32'h5A00_0000 + i);
         end
      end
      step(1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
   endtask

   task automatic test_back_to_back();
      logic [4:0] want [6] = '{5'b10100, 5'b10100, 5'b00000, 5'b00000, 5'b01000, 5'b10100};
      logic [1:0] rvs  [6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b1, 32'h0000_1000, rvs[i], 32'h1111_0000 + i);
         total++;
         if (obs() !== want[i]) begin
            bad++; $display("FAIL b2b_cycle_%0d: got %b want %b", i, obs(), want[i]);
         end
      end
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b0, 32'h0, 2'b01, 32'h2222_0000 + i);
         total++;
         if ({obs(), master_resp.rdata} !== {5'b01000, 32'h2222_0000 + i}) begin
            bad++; $display("FAIL b2b_drain_%0d: got %b/%h want %b/%h", i, obs(),
                            master_resp.rdata, 5'b01000, 32'h2222_0000 + i);
         end
      end
      step(1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
      total++;
      if (obs() !== 5'b00000) begin
         bad++; $display("FAIL b2b_idle: got %b want %b", obs(), 5'b00000);
      end
   endtask

   task automatic test_switch();
      logic [31:0] addrs [5] = '{32'h0000_2000, 32'h3000_0000, 32'h3000_0000, 32'h3000_0000, 32'h3000_0000};
      logic [1:0]  rvs   [5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
      logic [4:0]  want  [5] = '{5'b10100, 5'b00000, 5'b00000, 5'b01000, 5'b10010};
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, addrs[i], rvs[i], 32'h3333_0000);
         total++;
         if (obs() !== want[i]) begin
            bad++; $display("FAIL switch_cycle_%0d: got %b want %b", i, obs(), want[i]);
         end
      end
      step(1'b0, 1'b0, 32'h0, 2'b10, 32'h4444_0001);
      total++;
      if ({obs(), master_resp.rdata} !== {5'b01000, 32'h4444_0001}) begin
         bad++; $display("FAIL switch_resp: got %b/%h want %b/%h", obs(), master_resp.rdata,
                         5'b01000, 32'h4444_0001);
      end
      step(1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
   endtask

   task automatic test_error();
      step(1'b0, 1'b1, 32'h0000_3000, 2'b00, 32'h0);
      total++;
      if (obs() !== 5'b10100) begin
         bad++; $display("FAIL err_setup: got %b want %b", obs(), 5'b10100);
      end
      step(1'b0, 1'b0, 32'h0, 2'b10, 32'h6666_0000);
      total++;
      if (obs() !== 5'b00000) begin
         bad++; $display("FAIL err_wrong_port_dropped: got %b want %b", obs(), 5'b00000);
      end
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
         total++;
         if (obs() !== 5'b00001) begin
            bad++; $display("FAIL err_sticky_%0d: got %b want %b", i, obs(), 5'b00001);
         end
      end
      step(1'b1, 1'b0, 32'h0, 2'b00, 32'h0);
      step(1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
      total++;
      if (obs() !== 5'b00000) begin
         bad++; $display("FAIL err_cleared: got %b want %b", obs(), 5'b00000);
      end
      // An immediate grant to port 1 proves the outstanding count was cleared.
      step(1'b0, 1'b1, 32'h3000_0008, 2'b00, 32'h0);
      total++;
      if (obs() !== 5'b10010) begin
         bad++; $display("FAIL err_cnt_cleared: got %b want %b", obs(), 5'b10010);
      end
      step(1'b0, 1'b0, 32'h0, 2'b10, 32'h7777_0000);
      total++;
      if (obs() !== 5'b01000) begin
         bad++; $display("FAIL err_post_resp: got %b want %b", obs(), 5'b01000);
      end
      step(1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b1, 32'h0000_4000, 2'b00, 32'h0);
         total++;
         if (obs() !== 5'b10100) begin
            bad++; $display("FAIL rmid_grant_%0d: got %b want %b", i, obs(), 5'b10100);
         end
      end
      step(1'b1, 1'b1, 32'h0000_4000, 2'b00, 32'h0);
      total++;
      if (obs() !== 5'b00000) begin
         bad++; $display("FAIL rmid_in_reset: got %b want %b", obs(), 5'b00000);
      end
      step(1'b0, 1'b0, 32'h0, 2'b01, 32'h8888_0000);
      total++;
      if (obs() !== 5'b00000) begin
         bad++; $display("FAIL rmid_late_1: got %b want %b", obs(), 5'b00000);
      end
      step(1'b0, 1'b0, 32'h0, 2'b01, 32'h8888_0001);
      total++;
      if (obs() !== 5'b00001) begin
         bad++; $display("FAIL rmid_late_2: got %b want %b", obs(), 5'b00001);
      end
      step(1'b0, 1'b1, 32'h3000_0010, 2'b00, 32'h0);
      total++;
      if (obs() !== 5'b10011) begin
         bad++; $display("FAIL rmid_cnt_zero: got %b want %b", obs(), 5'b10011);
      end
      step(1'b0, 1'b0, 32'h0, 2'b10, 32'h9999_0000);
      total++;
      if ({obs(), master_resp.rdata} !== {5'b01001, 32'h9999_0000}) begin
         bad++; $display("FAIL rmid_final_resp: got %b/%h want %b/%h", obs(), master_resp.rdata,
                         5'b01001, 32'h9999_0000);
      end
      step(1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
   endtask

   initial begin
      rst_i      = 1'b1;
      master_req = '0;
      gnt_en     = 2'b11;
      rv         = 2'b00;
      rd0        = 32'h0;
      rd1        = 32'h0;
      test_reset();
      test_safe_read();
      test_boundary();
      test_back_to_back();
      test_switch();
      test_error();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
